// File: rtl/veh_sense.sv
// Vehicle presence sensor: synchronizes and debounces a loop detector, queues arrivals and
// raises a car-waiting request. Optional stuck-detector fail-safe under macro STUCK_DET_EN.
//
// state | meaning
// IDLE  | no queued cars, no request
// REQ   | cars queued, request raised, counting arrivals
// SERVE | country road green, request held while a car sits on the loop
module veh_sense #(
   parameter int DEB_CYC   = 4,
   parameter int MAX_CARS  = 15,
   parameter int STUCK_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_det,
   input  logic       cr_green,
   output logic       x,
   output logic [3:0] car_cnt,
   output logic       det,
   output logic       stuck
);

   typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

   localparam logic [3:0] DEB_TC = 4'(DEB_CYC - 1);
   localparam logic [3:0] CNT_MAX = 4'(MAX_CARS);

   if (DEB_CYC < 2 || DEB_CYC > 15) begin : g_chk_deb
      $error("veh_sense: DEB_CYC out of range");
   end
   if (MAX_CARS < 1 || MAX_CARS > 15) begin : g_chk_max
      $error("veh_sense: MAX_CARS out of range");
   end
   if (STUCK_CYC < 1) begin : g_chk_stuck
      $error("veh_sense: STUCK_CYC out of range");
   end

   state_t     state;
   logic       sync1, sync2;
   logic [3:0] deb_cnt;
   logic       arrival;
   logic       stuck_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw_det;
         sync2 <= sync1;
      end
   end

   // arrival is registered alongside det so it is high exactly in the first det=1 cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         det     <= 1'b0;
         deb_cnt <= 4'd0;
         arrival <= 1'b0;
      end else begin
         arrival <= 1'b0;
         if (sync2 == det) begin
            deb_cnt <= 4'd0;
         end else if (deb_cnt == DEB_TC) begin
            det     <= sync2;
            deb_cnt <= 4'd0;
            arrival <= sync2;
         end else begin
            deb_cnt <= deb_cnt + 4'd1;
         end
      end
   end

`ifdef STUCK_DET_EN
   localparam int SW = $clog2(STUCK_CYC + 1);
   localparam logic [SW-1:0] STUCK_TC = SW'(STUCK_CYC - 1);

   logic [SW-1:0] stuck_cnt;

   assign stuck_set = det && (stuck_cnt == STUCK_TC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stuck_cnt <= '0;
         stuck     <= 1'b0;
      end else if (!det) begin
         stuck_cnt <= '0;
      end else if (stuck_set) begin
         stuck <= 1'b1;
      end else begin
         stuck_cnt <= stuck_cnt + SW'(1);
      end
   end
`else
   assign stuck_set = 1'b0;
   assign stuck     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         x       <= 1'b0;
         car_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (arrival && !cr_green) begin
                  state   <= REQ;
                  car_cnt <= 4'd1;
                  x       <= 1'b1;
               end else begin
                  car_cnt <= 4'd0;
                  x       <= 1'b0;
               end
            end
            REQ: begin
               if (cr_green) begin
                  state <= SERVE;
                  x     <= det;
               end else begin
                  x <= 1'b1;
                  if (arrival && car_cnt < CNT_MAX)
                     car_cnt <= car_cnt + 4'd1;
               end
            end
            SERVE: begin
               x <= det;
               // green ending: a simultaneous arrival opens a fresh queue
               if (!cr_green) begin
                  if (arrival) begin
                     state   <= REQ;
                     car_cnt <= 4'd1;
                     x       <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     car_cnt <= 4'd0;
                     x       <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               car_cnt <= 4'd0;
               x       <= 1'b0;
            end
         endcase
`ifdef STUCK_DET_EN
         if (stuck || stuck_set)
            x <= 1'b1;
`endif
      end
   end

endmodule
